// File: rtl/fp_divider.sv
// Floating-point divider: quotient = a / b on a {sign, exp, man} word format.
// Mantissas go through a bit-serial restoring divide (one quotient bit per
// cycle), so latency is fixed regardless of operand values.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  operand handshake (ready while idle)
//   a, b            dividend / divisor
//   out_valid/ready result handshake (valid while done)
//   quotient        a / b, truncated, saturating on overflow, flushed on underflow
//   div_by_zero     set alongside the result when b == 0
module fp_divider #(
  parameter int unsigned EXPONENT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic        div_by_zero
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned MAN_W  = WORD_W - 1 - EXPONENT;
  localparam int unsigned SIG_W  = MAN_W + 1;           // significand with hidden bit
  localparam int unsigned Q_W    = MAN_W + 2;           // quotient bits produced
  localparam int unsigned EXP_W  = EXPONENT + 2;        // signed working exponent
  localparam int unsigned ITERS  = Q_W;
  localparam int unsigned CNT_W  = $clog2(ITERS + 1);
  localparam int unsigned BIAS   = (1 << (EXPONENT - 1)) - 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               sign_r;
  logic               a_zero;
  logic               b_zero;
  logic [EXP_W-1:0]   exp_r;
  logic [SIG_W-1:0]   div_r;
  logic [Q_W-1:0]     rem_r;
  logic [Q_W-1:0]     q_r;

  logic [Q_W-1:0]     rem_sub;
  logic               rem_ge;
  logic [EXP_W-1:0]   exp_n;
  logic [MAN_W-1:0]   man_n;
  logic [WORD_W-1:0]  result;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (cnt == CNT_W'(ITERS)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Restoring step: trial-subtract the divisor from the partial remainder
  always_comb begin
    rem_sub = rem_r - Q_W'(div_r);
    rem_ge  = (rem_r >= Q_W'(div_r));
  end

  // Normalise the quotient and apply the special-case priority
  always_comb begin
    exp_n = exp_r;
    man_n = q_r[MAN_W:1];
    if (!q_r[Q_W-1]) begin
      exp_n = exp_r - EXP_W'(1);
      man_n = q_r[MAN_W-1:0];
    end
    if (b_zero)                  result = {sign_r, {(WORD_W-1){1'b1}}};
    else if (a_zero)             result = '0;
    else if (exp_n[EXP_W-1])     result = '0;
    else if (exp_n[EXP_W-2])     result = {sign_r, {(WORD_W-1){1'b1}}};
    else                         result = {sign_r, exp_n[EXPONENT-1:0], man_n};
  end

  // Datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      sign_r      <= 1'b0;
      a_zero      <= 1'b0;
      b_zero      <= 1'b0;
      exp_r       <= '0;
      div_r       <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt    <= '0;
            sign_r <= a[WORD_W-1] ^ b[WORD_W-1];
            a_zero <= (a == '0);
            b_zero <= (b == '0);
            exp_r  <= EXP_W'(a[WORD_W-2 -: EXPONENT]) - EXP_W'(b[WORD_W-2 -: EXPONENT])
                      + EXP_W'(BIAS);
            div_r  <= {1'b1, b[MAN_W-1:0]};
            rem_r  <= Q_W'({1'b1, a[MAN_W-1:0]});
            q_r    <= '0;
          end
        end
        CALC: begin
          if (cnt != CNT_W'(ITERS)) begin
            cnt <= cnt + CNT_W'(1);
            q_r <= {q_r[Q_W-2:0], rem_ge};
            // Remainder stays below the divisor after a step, so the shift never loses a bit
            if (rem_ge) rem_r <= {rem_sub[Q_W-2:0], 1'b0};
            else        rem_r <= {rem_r[Q_W-2:0], 1'b0};
          end else begin
            quotient    <= result;
            div_by_zero <= b_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed corner cases, backpressure,
// mid-operation reset and randomized operands against a reference model.
module tb_fp_divider;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic        div_by_zero;

  int n_checks;
  int n_fail;

  fp_divider #(.EXPONENT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {div_by_zero, quotient} from real-valued division rules
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    longint      n, d, qv;
    int          e;
    logic [22:0] man;
    s = x[31] ^ y[31];
    if (y == 32'h0) return {1'b1, s, 31'h7FFFFFFF};
    if (x == 32'h0) return 33'h0;
    n  = longint'({1'b1, x[22:0]}) * 64'd16777216;
    d  = longint'({1'b1, y[22:0]});
    qv = n / d;
    e  = int'(x[30:23]) - int'(y[30:23]) + 127;
    if (qv >= 64'd16777216) man = qv[23:1];
    else begin
      man = qv[22:0];
      e   = e - 1;
    end
    if (e < 0)   return 33'h0;
    if (e > 255) return {1'b0, s, 31'h7FFFFFFF};
    return {1'b0, s, 8'(e), man};
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 60);
  endtask

  // Full transaction from IDLE; checks latency, result and flag, then consumes
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb);
    logic [32:0] exp_r;
    int          lat;
    exp_r = model(ta, tb);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check({tag, "_latency"}, 32'(lat), 32'd26);
    check({tag, "_quotient"}, quotient, exp_r[31:0]);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_r[32]));
    @(posedge clk); #1;
  endtask

  initial begin
    int          lat;
    logic        seen;
    logic [31:0] ra, rb;
    logic [32:0] m;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", quotient, 32'h0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    run_op("six_by_two", 32'h40C00000, 32'h40000000);
    check("six_by_two_const", quotient, 32'h40400000);
    run_op("one_third", 32'h3F800000, 32'h40400000);
    run_op("neg_sixteen", 32'hC1000000, 32'h3F000000);
    run_op("zero_a", 32'h00000000, 32'h3F800000);
    run_op("div_zero_neg", 32'hBF800000, 32'h00000000);
    run_op("zero_zero", 32'h00000000, 32'h00000000);
    run_op("overflow", 32'h7F000000, 32'h00800000);
    run_op("underflow", 32'h00800000, 32'h7F000000);

    // Backpressure: result held, new operands ignored while done
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 32'h40C00000;
    b         = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd26);
    a        = 32'hC1000000;
    b        = 32'h3F000000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_quotient", quotient, 32'h40400000);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    a = 32'h3F800000;
    b = 32'h40400000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_next_latency", 32'(lat), 32'd26);
    check("bp_next_quotient", quotient, 32'h3EAAAAAA);
    @(posedge clk); #1;

    // Leave a non-zero result behind before the mid-operation reset
    run_op("pre_reset", 32'h40C00000, 32'h40000000);

    in_valid = 1'b1;
    a        = 32'h3F800000;
    b        = 32'h40400000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_quotient", quotient, 32'h0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);
    run_op("after_reset", 32'h40C00000, 32'h40000000);

    // Randomized operands, exponents mostly kept near the middle of range
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(1, 0) == 1) begin
        ra[30:23] = 8'($urandom_range(190, 64));
        rb[30:23] = 8'($urandom_range(190, 64));
      end
      if ($urandom_range(15, 0) == 0) ra = 32'h0;
      if ($urandom_range(15, 0) == 0) rb = 32'h0;
      m = model(ra, rb);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a         = ra;
      b         = rb;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(lat);
      check("rand_latency", 32'(lat), 32'd26);
      check("rand_quotient", quotient, m[31:0]);
      check("rand_dbz", 32'(div_by_zero), 32'(m[32]));
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 Parameter: EXPONENT, default 8; exponent field width. Word is 32 bits; mantissa field is 31-EXPONENT bits (23 at default). All values below are for the default.
REQ-002 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  in  1  operand pair presented.
REQ-005 Port: in_ready  out  1  block can accept an operand pair.
REQ-006 Port: a  in  32  dividend, {sign, exp[7:0], man[22:0]}, bias 127.
REQ-007 Port: b  in  32  divisor, same format as a.
REQ-008 Port: out_valid  out  1  quotient available.
REQ-009 Port: out_ready  in  1  consumer takes the quotient.
REQ-010 Port: quotient  out  32  result a/b, same format as a.
REQ-011 Port: div_by_zero  out  1  set with out_valid when b == 0.

Function
REQ-012 States SHALL be IDLE, CALC and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-013 IDLE: in_valid = 1 at an edge SHALL capture a and b and move to CALC with the iteration counter at 0; in_valid = 0 SHALL leave IDLE unchanged.
REQ-014 CALC SHALL be a restoring divide of N = {1,man_a} << 24 by D = {1,man_b}, producing one quotient bit per cycle, MSB first, for 25 cycles; the 25-bit quotient Q = floor(N/D), in [2^23, 2^25).
REQ-015 After the 25th iteration the next edge SHALL enter DONE; out_valid SHALL first be high 26 edges after the accepting edge; latency SHALL be fixed, including zero and divide-by-zero operands.
REQ-016 DONE: quotient and div_by_zero SHALL hold stable while out_ready = 0; out_valid & out_ready at an edge SHALL return to IDLE, and no new operand SHALL be accepted on that same edge.
REQ-017 sign = a[31] ^ b[31].
REQ-018 Raw exponent: E = a[30:23] - b[30:23] + 127, evaluated as a 10-bit two's-complement value.
REQ-019 Normalise: if Q[24] = 1, man = Q[23:1] and exp = E; otherwise man = Q[22:0] and exp = E - 1. Truncate with no rounding.
REQ-020 Special cases, highest priority first:
  - b == 32'h0 (sign bit included): quotient = {sign, 31'h7FFFFFFF}, div_by_zero = 1.
  - a == 32'h0: quotient = 32'h0.
  - exp[9] = 1 (negative, underflow): quotient = 32'h0.
  - exp[8] = 1 (overflow): quotient = {sign, 31'h7FFFFFFF}.
  - Otherwise: quotient = {sign, exp[7:0], man}.
REQ-021 div_by_zero SHALL be 0 in every case other than b == 0.
REQ-022 Inputs are not checked for denormal, Inf or NaN; exponent fields are treated arithmetically, and exp = 0 yields exponent field 00 with the computed man.
REQ-023 In IDLE and CALC, quotient and div_by_zero SHALL hold their last value; outputs are only significant while out_valid = 1.

Reset
REQ-024 rst = 1 at an edge SHALL force IDLE, counter 0, quotient = 0, div_by_zero = 0, out_valid = 0, in_ready = 1, regardless of state. Reset has priority over every handshake.
REQ-025 Reset during CALC or DONE SHALL discard the operation; no out_valid pulse SHALL follow from it.
REQ-026 in_ready SHALL be 1 on the first edge after rst is released.

Verification
REQ-027 a = 40C00000, b = 40000000 (6.0/2.0) -> quotient = 40400000, div_by_zero = 0, out_valid exactly 26 edges after acceptance.
REQ-028 a = 3F800000, b = 40400000 (1/3) -> quotient = 3EAAAAAA (truncated); a = C1000000, b = 3F000000 -> quotient = C1800000.
REQ-029 Zero operands:
  - a = 00000000, b = 3F800000 -> quotient = 00000000.
  - a = BF800000, b = 00000000 -> quotient = FFFFFFFF, div_by_zero = 1.
  - a = 0, b = 0 -> quotient = 7FFFFFFF, div_by_zero = 1.
REQ-030 Range limits: a = 7F000000, b = 00800000 -> quotient = 7FFFFFFF (overflow); a = 00800000, b = 7F000000 -> quotient = 00000000 (underflow).
REQ-031 Backpressure:
  - Hold out_ready = 0 for 10 cycles in DONE -> quotient stable, in_ready = 0, a second in_valid is ignored.
  - Then out_ready = 1 -> IDLE on the next edge, and the following pair is accepted one edge later.
REQ-032 Reset mid-operation: assert rst at CALC iteration 12 -> next cycle in_ready = 1, out_valid = 0, quotient = 0; a fresh 6.0/2.0 then completes with the correct result and latency.
